multi_pb_debouncer: RTL

- Parametrised N-channel push-button conditioner: per-channel 2-FF synchroniser, saturating-counter debounce, edge pulses, long-press detection.
- Sits between the board button pins and the control FSMs / host-command logic.
- Generalises the single-channel debouncer with:
  - channel count and input polarity as parameters;
  - registered edge pulses;
  - a long-press event;
  - optional auto-repeat.

---
 rtl/multi_pb_debouncer.sv | 108 ++++++++++
 1 files changed

// File: rtl/multi_pb_debouncer.sv
// N-channel push-button conditioner: 2-FF sync, saturating debounce, edge pulses, long-press.
// Optional auto-repeat when DEBOUNCE_AUTOREPEAT_EN is defined; otherwise pb_repeat is tied to 0.
module multi_pb_debouncer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 20,
  parameter int ACTIVE_LOW = 1,
  parameter int HOLD_W     = 24,
  parameter int HOLD_CYC   = 10_000_000,
  parameter int REPEAT_CYC = 2_500_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] pb_in,
  output logic [NUM_CH-1:0] pb_state,
  output logic [NUM_CH-1:0] pb_down,
  output logic [NUM_CH-1:0] pb_up,
  output logic [NUM_CH-1:0] pb_long,
  output logic [NUM_CH-1:0] pb_repeat,
  output logic              any_pressed
);

  localparam logic              INV      = (ACTIVE_LOW != 0);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_M1  = HOLD_W'(HOLD_CYC - 1);

  assign any_pressed = |pb_state;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic              s0, s1;
    logic              state_q, down_q, up_q, long_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic              flip, state_nxt;

    // Toggle only after 2^CNT_W consecutive disagreeing samples.
    assign flip      = (s1 != state_q) && (cnt_q == '1);
    assign state_nxt = state_q ^ flip;

    always_ff @(posedge clk) begin
      if (!reset) begin
        s0      <= 1'b0;
        s1      <= 1'b0;
        cnt_q   <= '0;
        state_q <= 1'b0;
        down_q  <= 1'b0;
        up_q    <= 1'b0;
        hold_q  <= '0;
        long_q  <= 1'b0;
      end else begin
        s0      <= pb_in[ch] ^ INV;
        s1      <= s0;
        if ((s1 == state_q) || flip)
          cnt_q <= '0;
        else
          cnt_q <= cnt_q + 1'b1;
        state_q <= state_nxt;
        down_q  <= flip & ~state_q;
        up_q    <= flip & state_q;
        if (!state_q)
          hold_q <= '0;
        else if (hold_q != HOLD_LIM)
          hold_q <= hold_q + 1'b1;
        // A release landing on the same edge suppresses the long-press pulse.
        long_q  <= state_q & state_nxt & (hold_q == HOLD_M1);
      end
    end

    assign pb_state[ch] = state_q;
    assign pb_down[ch]  = down_q;
    assign pb_up[ch]    = up_q;
    assign pb_long[ch]  = long_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [HOLD_W-1:0] REP_M1 = HOLD_W'(REPEAT_CYC - 1);
    logic [HOLD_W-1:0] rep_q;
    logic              rep_pls_q;
    logic              armed;

    // Saturated hold counter means pb_long already fired for this press.
    assign armed = state_q & (hold_q == HOLD_LIM);

    always_ff @(posedge clk) begin
      if (!reset) begin
        rep_q     <= '0;
        rep_pls_q <= 1'b0;
      end else if (!state_nxt) begin
        rep_q     <= '0;
        rep_pls_q <= 1'b0;
      end else if (armed) begin
        if (rep_q == REP_M1) begin
          rep_q     <= '0;
          rep_pls_q <= 1'b1;
        end else begin
          rep_q     <= rep_q + 1'b1;
          rep_pls_q <= 1'b0;
        end
      end else begin
        rep_pls_q <= 1'b0;
      end
    end

    assign pb_repeat[ch] = rep_pls_q;
`else
    assign pb_repeat[ch] = 1'b0;
`endif
  end

endmodule
